sram_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM (sram_A/B/C style: 1-cycle registered read, write on posedge when we=1) among NUM_REQ requesters, e.g. SPI loader (req 0) and tile_processor (req 1).
- Round-robin arbitration with optional locked bursts; registered SRAM-side outputs; per-requester read-data return.
- Replaces ad-hoc priority muxing in front of each SRAM instance in top_npu_system.

---
 rtl/npu_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/sram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: arbiter FSM states and the default SRAM geometry
// used by the sram_* instances and the port arbiter in front of them.
package npu_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority one-hot picker: first asserted request at or after ptr,
// wrapping past N-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin : pick
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with locked bursts sharing one single-port synchronous
// SRAM; registered SRAM-side outputs and per-requester read-data return.
module sram_port_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = npu_pkg::ADDR_W,
    parameter int DATA_W    = npu_pkg::DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      sram_we,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_din,
    input  logic [DATA_W-1:0]         sram_dout,
    output logic                      busy
);
    import npu_pkg::*;

    // Handshake: gnt[k] is the accept strobe; req[k] must stay high with
    // stable lock/we/addr/wdata until the cycle gnt[k] is seen high.
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   burst_cnt;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [NUM_REQ-1:0] gnt_c;
    logic [IDX_W-1:0]   gnt_idx;
    logic               acc;

    logic               rd_v1, rd_v2;
    logic [IDX_W-1:0]   rd_id1, rd_id2;

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        gnt_c   = '0;
        gnt_idx = pick_idx;
        if (state == ARB) begin
            gnt_c = pick_gnt;
        end else begin
            gnt_idx = owner;
            if (req[owner]) gnt_c[owner] = 1'b1;
        end
    end

    assign acc  = |gnt_c;
    // Grant is forced low while reset is asserted, even with requests pending.
    assign gnt  = rst_n ? gnt_c : '0;
    assign busy = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            rd_v1     <= 1'b0;
            rd_id1    <= '0;
            rd_v2     <= 1'b0;
            rd_id2    <= '0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            sram_we <= acc && we[gnt_idx];
            if (acc) begin
                sram_addr <= addr[gnt_idx*ADDR_W +: ADDR_W];
                sram_din  <= wdata[gnt_idx*DATA_W +: DATA_W];
            end

            // Issue stage, SRAM read stage, then capture: gnt -> rvalid is 3 cycles.
            rd_v1  <= acc && !we[gnt_idx];
            rd_id1 <= gnt_idx;
            rd_v2  <= rd_v1;
            rd_id2 <= rd_id1;
            rvalid <= '0;
            if (rd_v2) begin
                rvalid[rd_id2] <= 1'b1;
                rdata          <= sram_dout;
            end

            case (state)
                ARB: begin
                    if (acc) begin
                        ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        // With MAX_BURST=1 the first access already exhausts the burst.
                        if (lock[gnt_idx] && (MAX_BURST > 1)) begin
                            state     <= LOCKED;
                            owner     <= gnt_idx;
                            burst_cnt <= CNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (!req[owner]) begin
                        state     <= ARB;
                        burst_cnt <= '0;
                    end else if (!lock[owner] || burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state     <= ARB;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (2 requesters, MAX_BURST=16) with a
// behavioural single-port SRAM preloaded with mem[i] = (i + 0x30) mod 256.
module tb_sram_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      sram_we;
    logic [ADDR_W-1:0]         sram_addr;
    logic [DATA_W-1:0]         sram_din;
    logic [DATA_W-1:0]         sram_dout;
    logic                      busy;

    logic [DATA_W-1:0] mem [0:1023];

    int tests;
    int failed;

    sram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: write on posedge, 1-cycle registered read (read-before-write)
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                          input logic [9:0] a0, input logic [9:0] a1,
                          input logic [7:0] d0, input logic [7:0] d1);
        req   = r;
        lock  = l;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 'h30);
        rst_n     = 1'b0;
        sram_dout = '0;
        set_in(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);

        // ---- reset state
        repeat (2) next_cycle();
        sample();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_sram_we", 32'(sram_we), 0);
        chk("rst_sram_addr", 32'(sram_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ---- T1: alternating reads, no lock
        set_in(2'b11, 2'b00, 2'b00, 10'h005, 10'h00A, 8'h0, 8'h0);
        sample(); chk("t1_c0_gnt", 32'(gnt), 32'h1);
        next_cycle();
        sample(); chk("t1_c1_gnt", 32'(gnt), 32'h2);
        chk("t1_c1_addr", 32'(sram_addr), 32'h005);
        chk("t1_c1_we", 32'(sram_we), 0);
        next_cycle();
        sample(); chk("t1_c2_gnt", 32'(gnt), 32'h1);
        chk("t1_c2_addr", 32'(sram_addr), 32'h00A);
        next_cycle();
        sample(); chk("t1_c3_gnt", 32'(gnt), 32'h2);
        chk("t1_c3_addr", 32'(sram_addr), 32'h005);
        chk("t1_c3_rvalid", 32'(rvalid), 32'h1);
        chk("t1_c3_rdata", 32'(rdata), 32'h35);
        next_cycle();
        req = 2'b00;
        sample(); chk("t1_c4_gnt", 32'(gnt), 0);
        chk("t1_c4_rvalid", 32'(rvalid), 32'h2);
        chk("t1_c4_rdata", 32'(rdata), 32'h3A);
        next_cycle();
        sample(); chk("t1_c5_rvalid", 32'(rvalid), 32'h1);
        chk("t1_c5_rdata", 32'(rdata), 32'h35);
        next_cycle();
        sample(); chk("t1_c6_rvalid", 32'(rvalid), 32'h2);
        chk("t1_c6_rdata", 32'(rdata), 32'h3A);
        next_cycle();
        sample(); chk("t1_c7_rvalid", 32'(rvalid), 0);
        next_cycle();

        // ---- T2: requester 1 locked write burst, requester 0 pending
        set_in(2'b10, 2'b10, 2'b10, 10'h005, 10'h040, 8'h0, 8'h11);
        sample(); chk("t2_a_gnt", 32'(gnt), 32'h2);
        chk("t2_a_busy", 32'(busy), 0);
        next_cycle();
        set_in(2'b11, 2'b10, 2'b10, 10'h005, 10'h041, 8'h0, 8'h12);
        sample(); chk("t2_b_gnt", 32'(gnt), 32'h2);
        chk("t2_b_busy", 32'(busy), 1);
        chk("t2_b_we", 32'(sram_we), 1);
        chk("t2_b_addr", 32'(sram_addr), 32'h040);
        chk("t2_b_din", 32'(sram_din), 32'h11);
        next_cycle();
        set_in(2'b11, 2'b10, 2'b10, 10'h005, 10'h042, 8'h0, 8'h13);
        sample(); chk("t2_c_gnt", 32'(gnt), 32'h2);
        chk("t2_c_busy", 32'(busy), 1);
        chk("t2_c_din", 32'(sram_din), 32'h12);
        next_cycle();
        set_in(2'b11, 2'b00, 2'b10, 10'h005, 10'h043, 8'h0, 8'h14);
        sample(); chk("t2_d_gnt", 32'(gnt), 32'h2);
        chk("t2_d_busy", 32'(busy), 1);
        chk("t2_d_addr", 32'(sram_addr), 32'h042);
        next_cycle();
        set_in(2'b01, 2'b00, 2'b00, 10'h005, 10'h043, 8'h0, 8'h14);
        sample(); chk("t2_e_gnt", 32'(gnt), 32'h1);
        chk("t2_e_busy", 32'(busy), 0);
        chk("t2_e_we", 32'(sram_we), 1);
        chk("t2_e_din", 32'(sram_din), 32'h14);
        chk("t2_e_rvalid", 32'(rvalid), 0);
        next_cycle();
        req = 2'b00;
        sample(); chk("t2_f_we", 32'(sram_we), 0);
        chk("t2_f_addr", 32'(sram_addr), 32'h005);
        next_cycle();
        next_cycle();
        sample(); chk("t2_h_rvalid", 32'(rvalid), 32'h1);
        chk("t2_h_rdata", 32'(rdata), 32'h35);
        next_cycle();

        // ---- T3: forced release after 16 locked grants to requester 0
        set_in(2'b01, 2'b01, 2'b00, 10'h010, 10'h00A, 8'h0, 8'h0);
        sample(); chk("t3_c0_gnt", 32'(gnt), 32'h1);
        chk("t3_c0_busy", 32'(busy), 0);
        next_cycle();
        req = 2'b11;
        for (int i = 1; i < 16; i++) begin
            sample(); chk($sformatf("t3_c%0d_gnt", i), 32'(gnt), 32'h1);
            chk($sformatf("t3_c%0d_busy", i), 32'(busy), 1);
            next_cycle();
        end
        sample(); chk("t3_c16_gnt", 32'(gnt), 32'h2);
        chk("t3_c16_busy", 32'(busy), 0);
        chk("t3_c16_rvalid", 32'(rvalid), 32'h1);
        chk("t3_c16_rdata", 32'(rdata), 32'h40);
        next_cycle();
        set_in(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
        sample(); chk("t3_c17_rvalid", 32'(rvalid), 32'h1);
        next_cycle();
        sample(); chk("t3_c18_rvalid", 32'(rvalid), 32'h1);
        next_cycle();
        sample(); chk("t3_c19_rvalid", 32'(rvalid), 32'h2);
        chk("t3_c19_rdata", 32'(rdata), 32'h3A);
        next_cycle();
        sample(); chk("t3_c20_rvalid", 32'(rvalid), 0);
        next_cycle();

        // ---- T4: locked owner idles one cycle -> idle release
        set_in(2'b10, 2'b10, 2'b00, 10'h00A, 10'h042, 8'h0, 8'h0);
        sample(); chk("t4_c0_gnt", 32'(gnt), 32'h2);
        next_cycle();
        req = 2'b11;
        sample(); chk("t4_c1_gnt", 32'(gnt), 32'h2);
        chk("t4_c1_busy", 32'(busy), 1);
        next_cycle();
        req = 2'b01;
        sample(); chk("t4_c2_gnt", 32'(gnt), 0);
        chk("t4_c2_busy", 32'(busy), 1);
        next_cycle();
        sample(); chk("t4_c3_gnt", 32'(gnt), 32'h1);
        chk("t4_c3_busy", 32'(busy), 0);
        chk("t4_c3_rvalid", 32'(rvalid), 32'h2);
        chk("t4_c3_rdata", 32'(rdata), 32'h13);
        next_cycle();
        req = 2'b00;
        sample(); chk("t4_c4_rvalid", 32'(rvalid), 32'h2);
        chk("t4_c4_rdata", 32'(rdata), 32'h13);
        next_cycle();
        sample(); chk("t4_c5_rvalid", 32'(rvalid), 0);
        next_cycle();
        sample(); chk("t4_c6_rvalid", 32'(rvalid), 32'h1);
        chk("t4_c6_rdata", 32'(rdata), 32'h3A);
        next_cycle();

        // ---- T5: write 0xA5 to 0x3FF then read it back
        set_in(2'b10, 2'b00, 2'b10, 10'h000, 10'h3FF, 8'h0, 8'hA5);
        sample(); chk("t5_c0_gnt", 32'(gnt), 32'h2);
        next_cycle();
        we = 2'b00;
        sample(); chk("t5_c1_gnt", 32'(gnt), 32'h2);
        chk("t5_c1_we", 32'(sram_we), 1);
        chk("t5_c1_addr", 32'(sram_addr), 32'h3FF);
        chk("t5_c1_din", 32'(sram_din), 32'hA5);
        next_cycle();
        req = 2'b00;
        sample(); chk("t5_c2_we", 32'(sram_we), 0);
        chk("t5_c2_addr", 32'(sram_addr), 32'h3FF);
        next_cycle();
        sample(); chk("t5_c3_rvalid", 32'(rvalid), 0);
        next_cycle();
        sample(); chk("t5_c4_rvalid", 32'(rvalid), 32'h2);
        chk("t5_c4_rdata", 32'(rdata), 32'hA5);
        next_cycle();

        // ---- T6: reset mid-burst with reads in flight
        set_in(2'b10, 2'b10, 2'b00, 10'h000, 10'h005, 8'h0, 8'h0);
        sample(); chk("t6_c0_gnt", 32'(gnt), 32'h2);
        next_cycle();
        sample(); chk("t6_c1_busy", 32'(busy), 1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_rvalid", 32'(rvalid), 0);
        chk("t6_rst_rdata", 32'(rdata), 0);
        chk("t6_rst_we", 32'(sram_we), 0);
        chk("t6_rst_addr", 32'(sram_addr), 0);
        chk("t6_rst_din", 32'(sram_din), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        req  = 2'b00;
        lock = 2'b00;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(); chk($sformatf("t6_post_rvalid%0d", i), 32'(rvalid), 0);
            next_cycle();
        end
        req = 2'b11;
        sample(); chk("t6_first_gnt", 32'(gnt), 32'h1);
        next_cycle();
        req = 2'b00;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
